// File: rtl/cnt_arb_pkg.sv
// Shared types and constants for the counter-sliced round-robin arbiter.
package cnt_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Counter mode: any mode with bit 1 set is a parallel load.
  localparam logic [1:0] MODE_HOLD  = 2'b00;
  localparam logic [1:0] MODE_COUNT = 2'b01;
  localparam logic [1:0] MODE_LOAD  = 2'b10;

  localparam int NREQ_DEF = 4;
  localparam int CW_DEF   = 4;

endpackage

// File: rtl/slice_counter.sv
// Mode-driven CW-bit slice counter: hold, increment modulo 2^CW, or parallel load.
module slice_counter
  import cnt_arb_pkg::*;
#(
  parameter int CW = CW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [1:0]    mode,
  input  logic [CW-1:0] d,
  output logic [CW-1:0] q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (mode[1]) begin
      q <= d;
    end else if (mode == MODE_COUNT) begin
      q <= q + 1'b1;
    end
  end

endmodule

// File: rtl/cnt_slice_arbiter.sv
// Round-robin arbiter whose grants are bounded by a loadable slice counter.
module cnt_slice_arbiter
  import cnt_arb_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int CW   = CW_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ*CW-1:0] load_val,
  input  logic               pause,
  output logic [NREQ-1:0]    gnt,
  output logic               busy,
  output logic [CW-1:0]      cnt_val,
  output logic               expire
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [CW-1:0] CNT_MAX = '1;
  localparam logic [NREQ-1:0] ONE = {{(NREQ-1){1'b0}}, 1'b1};

  state_t          state;
  logic [PW-1:0]   ptr;
  logic [PW-1:0]   win;
  logic [PW-1:0]   idx;
  logic            found;
  logic            owner_req;
  logic [1:0]      mode;
  logic [CW-1:0]   cnt_d;
  logic [CW-1:0]   lv [NREQ];

  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      lv[i] = load_val[i*CW +: CW];
    end
  end

  // First requester at or after ptr, wrapping modulo NREQ.
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = PW'((int'(ptr) + k) % NREQ);
      if (!found && req[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  assign owner_req = |(gnt & req);
  assign busy      = |gnt;

  always_comb begin
    mode  = MODE_HOLD;
    cnt_d = lv[win];
    if (state == IDLE) begin
      if (found) mode = MODE_LOAD;
    end else if (owner_req && !pause) begin
      mode = MODE_COUNT;
    end
  end

  slice_counter #(.CW(CW)) u_counter (
    .clk  (clk),
    .rst  (rst),
    .mode (mode),
    .d    (cnt_d),
    .q    (cnt_val)
  );

  // Release by the owner takes priority over both pause and wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      gnt    <= '0;
      expire <= 1'b0;
      ptr    <= '0;
    end else begin
      expire <= 1'b0;
      case (state)
        IDLE: begin
          if (found) begin
            gnt   <= ONE << win;
            ptr   <= (int'(win) == NREQ - 1) ? '0 : win + 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          if (!owner_req) begin
            gnt   <= '0;
            state <= IDLE;
          end else if (!pause && cnt_val == CNT_MAX) begin
            gnt    <= '0;
            expire <= 1'b1;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/cnt_slice_arbiter.md
CNT_SLICE_ARBITER -- requirements
Module: cnt_slice_arbiter

Interface
REQ-001 SHALL have parameter NREQ, default 4, number of requesters (2..8).
REQ-002 SHALL have parameter CW, default 4, counter width (mod-2^CW slice counter).
REQ-003 SHALL have port clk  input  1  clock; all state updates on the rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port req  input  NREQ  per-requester request, level-sensitive.
REQ-006 SHALL have port load_val  input  NREQ*CW  per-requester slice start value; requester i occupies bits [i*CW +: CW].
REQ-007 SHALL have port pause  input  1  freezes the slice counter while asserted.
REQ-008 SHALL have port gnt  output  NREQ  registered grant, one-hot or zero.
REQ-009 SHALL have port busy  output  1  high while any grant is active (OR of gnt).
REQ-010 SHALL have port cnt_val  output  CW  current slice counter value.
REQ-011 SHALL have port expire  output  1  one-cycle pulse when a slice ends by counter wrap.

Function
REQ-012 SHALL implement a two-state FSM: IDLE, RUN.
REQ-013 IDLE with req==0: gnt, expire, state and cnt_val hold, except expire SHALL be 0.
REQ-014 IDLE with any req set: on the next edge, gnt <= one-hot round-robin winner, counter <= winner's load_val (load mode), state <= RUN.
REQ-015 Round-robin: search starts at index ptr and increments modulo NREQ; ptr <= winner+1 mod NREQ on each grant; ptr resets to 0.
REQ-016 RUN, owner's req low: next edge gnt <= 0, counter holds, state <= IDLE, expire stays 0 (voluntary release).
REQ-017 RUN, owner's req high, pause high: counter holds (hold mode), gnt holds.
REQ-018 RUN, owner's req high, pause low, counter != 2^CW-1: counter <= counter+1 (count mode).
REQ-019 RUN, owner's req high, pause low, counter == 2^CW-1: counter <= 0 (wrap), expire <= 1 for one cycle, gnt <= 0, state <= IDLE.
REQ-020 Release priority: req-low (REQ-016) beats pause and wrap in the same cycle.
REQ-021 Grant duration with pause low = 2^CW - load_val cycles; load_val = 2^CW-1 gives a one-cycle grant.
REQ-022 There SHALL be exactly one IDLE cycle between any release/expiry and the next grant; no back-to-back grants.
REQ-023 req changes of non-owners during RUN SHALL have no effect until the next IDLE.
REQ-024 load_val SHALL be sampled only on the granting edge; later changes are ignored.
REQ-025 Counter arithmetic SHALL be unsigned CW-bit, modulo 2^CW.

Reset
REQ-026 rst high SHALL immediately force state=IDLE, gnt=0, busy=0, cnt_val=0, expire=0, ptr=0, including mid-slice.
REQ-027 The first edge after rst deasserts SHALL follow REQ-013/REQ-014 normally.

Structure
REQ-028 Package cnt_arb_pkg SHALL hold the state enum (IDLE, RUN), counter mode encoding (HOLD=00, COUNT=01, LOAD=1x), and default NREQ/CW.
REQ-029 The counter SHALL be a sub-module slice_counter: async-reset, mode-driven hold/count/parallel-load, CW wide; the FSM drives only its mode and data inputs.

Verification
REQ-030 Single req[1] high, load_val[1]=12, pause 0 -> gnt=0010 for 4 cycles, cnt_val 12,13,14,15, expire pulse on the edge cnt_val becomes 0.
REQ-031 req=1111 held, all load_val=15 -> grants 0001,0010,0100,1000,0001, each 1 cycle with 1 IDLE cycle between, expire every slice.
REQ-032 req[0] granted, load_val=0, pause high 3 cycles at cnt_val=5 -> cnt_val stays 5 for 3 cycles, expiry delayed by 3 cycles (19 grant cycles total).
REQ-033 req[2] granted at cnt_val=15, req[2] dropped in same cycle -> gnt=0, cnt_val stays 15, no expire pulse.
REQ-034 rst asserted mid-slice at cnt_val=9 -> outputs 0 immediately, next grant with req=1000 goes to index 3 and ptr restarts at 0 behaviour.
REQ-035 load_val changed during RUN -> counting continues from original sampled value.
